// File: rtl/btb_update_scheduler.sv
// Queues resolved-branch BTB updates from dual retire and drains one BTB write per cycle;
// also walks every BTB index to invalidate it on request. Optional macro: BTB_UPD_COALESCE_EN.
module btb_update_scheduler #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned IDX_W       = $clog2(BTB_ENTRIES),
    parameter int unsigned Q_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          upd0_valid,
    input  logic [ADDR_WIDTH-1:0]         upd0_pc,
    input  logic [ADDR_WIDTH-1:0]         upd0_target,
    input  logic                          upd0_taken,
    input  logic                          upd1_valid,
    input  logic [ADDR_WIDTH-1:0]         upd1_pc,
    input  logic [ADDR_WIDTH-1:0]         upd1_target,
    input  logic                          upd1_taken,
    output logic                          upd_ready,
    input  logic                          flush_req,
    output logic                          flush_busy,
    output logic                          flush_done,
    output logic                          btb_wr_en,
    output logic [IDX_W-1:0]              btb_wr_index,
    output logic [ADDR_WIDTH-IDX_W-3:0]   btb_wr_tag,
    output logic                          btb_wr_valid,
    output logic                          btb_wr_taken,
    output logic [ADDR_WIDTH-1:0]         btb_wr_target
);

    localparam int unsigned PTR_W = $clog2(Q_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // pc_word holds pc[ADDR_WIDTH-1:2]; its low IDX_W bits are the index, the rest the tag.
    typedef struct packed {
        logic [ADDR_WIDTH-3:0] pc_word;
        logic [ADDR_WIDTH-1:0] target;
        logic                  taken;
    } entry_t;

    typedef enum logic [0:0] {
        StRun,
        StFlush
    } state_e;

    state_e           state_q, state_d;
    entry_t           mem [Q_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             wr_en_q, wr_en_d;
    entry_t           wr_q, wr_d;

    entry_t           in0, in1, first, head;
    logic             accept, push0, push1, push_a, push_b, pop;
    logic [1:0]       n_push;
    logic             unused_pc_lsbs;

    assign in0 = {upd0_pc[ADDR_WIDTH-1:2], upd0_target, upd0_taken};
    assign in1 = {upd1_pc[ADDR_WIDTH-1:2], upd1_target, upd1_taken};
    assign unused_pc_lsbs = ^{upd0_pc[1:0], upd1_pc[1:0]};

    assign accept = (state_q == StRun) && ready_q && !flush_req;

`ifdef BTB_UPD_COALESCE_EN
    logic same_idx;
    assign same_idx = (upd0_pc[IDX_W+1:2] == upd1_pc[IDX_W+1:2]);
    assign push0    = accept && upd0_valid && !(upd1_valid && same_idx);
`else
    assign push0    = accept && upd0_valid;
`endif
    assign push1  = accept && upd1_valid;
    assign push_a = push0 || push1;
    assign push_b = push0 && push1;
    assign n_push = {1'b0, push0} + {1'b0, push1};
    assign first  = push0 ? in0 : in1;

    // An empty queue forwards the oldest incoming update straight to the write register;
    // it is still stored, but the read pointer skips over it.
    assign head = (count_q != '0) ? mem[rd_ptr_q] : first;
    assign pop  = (state_q == StRun) && !flush_req && ((count_q != '0) || push_a);

    always_ff @(posedge clk) begin
        if (push_a) begin
            mem[wr_ptr_q] <= first;
        end
        if (push_b) begin
            mem[wr_ptr_q + PTR_W'(1)] <= in1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        flush_cnt_d = flush_cnt_q;
        done_d      = 1'b0;
        wr_en_d     = 1'b0;
        wr_d        = '0;
        unique case (state_q)
            StRun: begin
                if (flush_req) begin
                    state_d     = StFlush;
                    rd_ptr_d    = '0;
                    wr_ptr_d    = '0;
                    count_d     = '0;
                    flush_cnt_d = '0;
                end else begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
                    count_d  = count_q + CNT_W'(n_push);
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        count_d  = count_d - CNT_W'(1);
                        wr_en_d  = 1'b1;
                        wr_d     = head;
                    end
                end
            end
            StFlush: begin
                flush_cnt_d = flush_cnt_q + IDX_W'(1);
                if (flush_cnt_q == IDX_W'(BTB_ENTRIES - 1)) begin
                    state_d     = StRun;
                    flush_cnt_d = '0;
                    done_d      = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase
        // Two free slots are needed because both retire ports may push next cycle.
        ready_d = (state_d == StRun) && (count_d <= CNT_W'(Q_DEPTH - 2));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            flush_cnt_q <= '0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_q        <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            flush_cnt_q <= flush_cnt_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            wr_en_q     <= wr_en_d;
            wr_q        <= wr_d;
        end
    end

    // The drain register is zero throughout a flush, so only the index needs a mux.
    assign flush_busy    = (state_q == StFlush);
    assign flush_done    = done_q;
    assign upd_ready     = ready_q;
    assign btb_wr_en     = wr_en_q || flush_busy;
    assign btb_wr_index  = flush_busy ? flush_cnt_q : wr_q.pc_word[IDX_W-1:0];
    assign btb_wr_tag    = wr_q.pc_word[ADDR_WIDTH-3:IDX_W];
    assign btb_wr_valid  = wr_en_q;
    assign btb_wr_taken  = wr_q.taken;
    assign btb_wr_target = wr_q.target;

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Randomized scoreboard bench for btb_update_scheduler against a queue-level reference model.
module tb_btb_update_scheduler;

    localparam int unsigned AW  = 32;
    localparam int unsigned ENT = 16;
    localparam int unsigned IW  = 4;
    localparam int unsigned QD  = 8;
    localparam int unsigned TW  = AW - IW - 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          upd0_valid = 1'b0, upd0_taken = 1'b0;
    logic [AW-1:0] upd0_pc = '0, upd0_target = '0;
    logic          upd1_valid = 1'b0, upd1_taken = 1'b0;
    logic [AW-1:0] upd1_pc = '0, upd1_target = '0;
    logic          flush_req = 1'b0;
    logic          upd_ready, flush_busy, flush_done;
    logic          btb_wr_en, btb_wr_valid, btb_wr_taken;
    logic [IW-1:0] btb_wr_index;
    logic [TW-1:0] btb_wr_tag;
    logic [AW-1:0] btb_wr_target;

    btb_update_scheduler #(
        .ADDR_WIDTH (AW),
        .BTB_ENTRIES(ENT),
        .IDX_W      (IW),
        .Q_DEPTH    (QD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .upd0_valid   (upd0_valid),
        .upd0_pc      (upd0_pc),
        .upd0_target  (upd0_target),
        .upd0_taken   (upd0_taken),
        .upd1_valid   (upd1_valid),
        .upd1_pc      (upd1_pc),
        .upd1_target  (upd1_target),
        .upd1_taken   (upd1_taken),
        .upd_ready    (upd_ready),
        .flush_req    (flush_req),
        .flush_busy   (flush_busy),
        .flush_done   (flush_done),
        .btb_wr_en    (btb_wr_en),
        .btb_wr_index (btb_wr_index),
        .btb_wr_tag   (btb_wr_tag),
        .btb_wr_valid (btb_wr_valid),
        .btb_wr_taken (btb_wr_taken),
        .btb_wr_target(btb_wr_target)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int            due;
        int            idx;
        logic [TW-1:0] tag;
        bit            valid;
        bit            taken;
        logic [AW-1:0] target;
    } wr_t;

    typedef struct {
        logic [AW-1:0] pc;
        logic [AW-1:0] target;
        bit            taken;
    } upd_t;

    wr_t  exp_wr[$];
    int   exp_done[$];

    // Reference model: list of accepted-but-unwritten updates plus flush window.
    upd_t mq[$];
    bit   m_flush = 1'b0;
    int   m_flush_last = 0;
    bit   m_ready = 1'b0;

    function automatic int idx_of(logic [AW-1:0] pc);
        return int'((pc >> 2) % ENT);
    endfunction

    function automatic wr_t mk_wr(int due, upd_t u);
        wr_t w;
        w.due    = due;
        w.idx    = idx_of(u.pc);
        w.tag    = TW'(u.pc >> (IW + 2));
        w.valid  = 1'b1;
        w.taken  = u.taken;
        w.target = u.target;
        return w;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_step();
        upd_t u;
        bit   keep0;
        check("upd_ready", 64'(upd_ready), 64'(m_ready));
        check("flush_busy", 64'(flush_busy), 64'(m_flush));
        if (m_flush) begin
            if (cyc == m_flush_last) begin
                m_flush = 1'b0;
                m_ready = 1'b1;
            end
        end else if (flush_req) begin
            mq.delete();
            m_flush      = 1'b1;
            m_flush_last = cyc + ENT;
            m_ready      = 1'b0;
            for (int i = 0; i < ENT; i++) begin
                exp_wr.push_back('{due: cyc + 1 + i, idx: i, tag: '0, valid: 1'b0,
                                   taken: 1'b0, target: '0});
            end
            exp_done.push_back(cyc + ENT + 1);
        end else begin
            if (m_ready) begin
                keep0 = upd0_valid;
`ifdef BTB_UPD_COALESCE_EN
                if (upd0_valid && upd1_valid && idx_of(upd0_pc) == idx_of(upd1_pc)) keep0 = 1'b0;
`endif
                if (keep0) mq.push_back('{pc: upd0_pc, target: upd0_target, taken: upd0_taken});
                if (upd1_valid) mq.push_back('{pc: upd1_pc, target: upd1_target, taken: upd1_taken});
            end
            if (mq.size() > 0) begin
                u = mq.pop_front();
                exp_wr.push_back(mk_wr(cyc + 1, u));
            end
            m_ready = (mq.size() <= QD - 2);
        end
    endtask

    task automatic drive(bit v0, logic [AW-1:0] p0, logic [AW-1:0] t0, bit k0,
                         bit v1, logic [AW-1:0] p1, logic [AW-1:0] t1, bit k1, bit fr);
        @(posedge clk);
        #1;
        upd0_valid = v0; upd0_pc = p0; upd0_target = t0; upd0_taken = k0;
        upd1_valid = v1; upd1_pc = p1; upd1_target = t1; upd1_taken = k1;
        flush_req  = fr;
        model_step();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, '0, '0, 0, 0, '0, '0, 0, 0);
    endtask

    task automatic set_idle_inputs();
        upd0_valid = 1'b0; upd1_valid = 1'b0; flush_req = 1'b0;
    endtask

    // Assumes the caller is already #1 past a rising edge.
    task automatic apply_reset(int n);
        rst = 1'b1;
        set_idle_inputs();
        while (exp_wr.size() > 0 && exp_wr[$].due >= cyc) void'(exp_wr.pop_back());
        while (exp_done.size() > 0 && exp_done[$] >= cyc) void'(exp_done.pop_back());
        mq.delete();
        m_flush = 1'b0;
        m_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        model_step();
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst) begin
            checks++;
            if (btb_wr_en || flush_busy || flush_done || upd_ready || btb_wr_valid ||
                btb_wr_index != '0 || btb_wr_tag != '0 || btb_wr_target != '0) begin
                errors++;
                $display("FAIL reset_outputs: wr_en=%0b busy=%0b done=%0b ready=%0b idx=%0h, required all 0 (cycle %0d)",
                         btb_wr_en, flush_busy, flush_done, upd_ready, btb_wr_index, cyc);
            end
        end else begin
            while (exp_wr.size() > 0 && exp_wr[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_write: got none, required index %0h in cycle %0d",
                         exp_wr[0].idx, exp_wr[0].due);
                void'(exp_wr.pop_front());
            end
            while (exp_done.size() > 0 && exp_done[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_flush_done: got none, required in cycle %0d", exp_done[0]);
                void'(exp_done.pop_front());
            end
            if (btb_wr_en) begin
                checks++;
                if (exp_wr.size() == 0 || exp_wr[0].due != cyc) begin
                    errors++;
                    $display("FAIL unexpected_write: got index %0h in cycle %0d, required no write",
                             btb_wr_index, cyc);
                end else begin
                    e = exp_wr.pop_front();
                    if (int'(btb_wr_index) != e.idx || btb_wr_tag != e.tag ||
                        btb_wr_valid != e.valid || btb_wr_taken != e.taken ||
                        btb_wr_target != e.target) begin
                        errors++;
                        $display("FAIL btb_write: got idx=%0h tag=%0h v=%0b t=%0b tgt=%0h, required idx=%0h tag=%0h v=%0b t=%0b tgt=%0h (cycle %0d)",
                                 btb_wr_index, btb_wr_tag, btb_wr_valid, btb_wr_taken, btb_wr_target,
                                 e.idx, e.tag, e.valid, e.taken, e.target, cyc);
                    end
                end
            end
            if (flush_done) begin
                checks++;
                if (exp_done.size() == 0 || exp_done[0] != cyc) begin
                    errors++;
                    $display("FAIL unexpected_flush_done: got pulse in cycle %0d, required none", cyc);
                end else begin
                    void'(exp_done.pop_front());
                end
            end
        end
    end

    initial begin : stimulus
        logic [AW-1:0] p0, p1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_step();

        // Single update right after reset release.
        drive(1, 32'h100, 32'h200, 1, 0, '0, '0, 0, 0);
        idle(2);
        // Two updates in one cycle, consecutive writes.
        drive(1, 32'h104, 32'h0a0, 0, 1, 32'h208, 32'h0b0, 1, 0);
        idle(3);
        // Saturate the queue until upd_ready drops.
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h1000 + 32'(i * 8), 32'h5000 + 32'(i), 1,
                  1, 32'h1004 + 32'(i * 8), 32'h6000 + 32'(i), 0, 0);
        end
        idle(12);
        // Flush with updates queued, including one presented alongside the request.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h2000 + 32'(i * 8), 32'h7000, 1, 1, 32'h2004 + 32'(i * 8), 32'h7100, 0, 0);
        end
        drive(1, 32'h3000, 32'h1, 1, 1, 32'h3004, 32'h2, 1, 1);
        idle(4);
        drive(0, '0, '0, 0, 0, '0, '0, 0, 1);
        idle(16);
        // Same-index pair.
        drive(1, 32'h104, 32'h111, 1, 1, 32'h144, 32'h222, 0, 0);
        idle(3);
        // Reset while the flush walk is at index 5.
        drive(0, '0, '0, 0, 0, '0, '0, 0, 1);
        idle(5);
        @(posedge clk);
        #1;
        check("flush_index_before_rst", 64'(btb_wr_index), 64'd5);
        apply_reset(2);
        idle(3);

        for (int n = 0; n < 3000; n++) begin
            p0 = $urandom();
            p1 = $urandom();
            if ($urandom_range(3) == 0) p1[IW+1:2] = p0[IW+1:2];
            if ($urandom_range(499) == 0) begin
                @(posedge clk);
                #1;
                apply_reset($urandom_range(1, 3));
            end else begin
                drive($urandom_range(3) != 0, p0, $urandom(), 1'($urandom()),
                      $urandom_range(3) != 0, p1, $urandom(), 1'($urandom()),
                      $urandom_range(99) == 0);
            end
        end
        idle(40);

        checks++;
        if (exp_wr.size() != 0 || exp_done.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: got %0d writes and %0d done pending, required 0",
                     exp_wr.size(), exp_done.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
